// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, the START/RUN/DONE handshake and a
// small return-address stack for call/return through the PC_LUT.
module pc_sequencer #(
    parameter int          D         = 12,
    parameter int unsigned START_PC  = 0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Stall,
    input  logic         Halt,
    input  logic         Jump,
    input  logic         Call,
    input  logic         Ret,
    input  logic [4:0]   Lut_idx,
    output logic [4:0]   addr_lut,
    input  logic [D-1:0] target,
    output logic [D-1:0] Prog_ctr,
    output logic         Valid,
    output logic         Done,
    output logic         Stack_err
);

    localparam int IW  = $clog2(RAS_DEPTH);
    localparam int SPW = IW + 1;
    localparam logic [SPW-1:0] SP_FULL    = SPW'(RAS_DEPTH);
    localparam logic [SPW-1:0] SP_ZERO    = {SPW{1'b0}};
    localparam logic [D-1:0]   START_PC_V = D'(START_PC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [D-1:0]   pc_r;
    logic [D-1:0]   pc_s;
    logic [D-1:0]   pc_inc_s;
    logic [SPW-1:0] sp_r;
    logic [SPW-1:0] sp_s;
    logic [SPW-1:0] sp_dec_s;
    logic [IW-1:0]  top_idx_s;
    logic [IW-1:0]  push_idx_s;
    logic           push_s;
    logic           err_r;
    logic           err_s;
    logic           valid_r;
    logic           done_r;
    logic [D-1:0]   ras_r [RAS_DEPTH];

    assign addr_lut   = Lut_idx;
    assign Prog_ctr   = pc_r;
    assign Valid      = valid_r;
    assign Done       = done_r;
    assign Stack_err  = err_r;

    // Modulo-2**D increment doubles as the pushed return address.
    assign pc_inc_s   = pc_r + D'(1);
    assign sp_dec_s   = sp_r - SPW'(1);
    assign top_idx_s  = sp_dec_s[IW-1:0];
    assign push_idx_s = sp_r[IW-1:0];

    // Next-state, next-PC and stack-pointer selection with Halt > Ret > Call > Jump priority.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        sp_s    = sp_r;
        err_s   = err_r;
        push_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_s = ST_RUN;
                    pc_s    = START_PC_V;
                    sp_s    = SP_ZERO;
                    err_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (Stall) begin
                    state_s = state_r;
                end else if (Halt) begin
                    state_s = ST_DONE;
                end else if (Ret) begin
                    if (sp_r != SP_ZERO) begin
                        pc_s = ras_r[top_idx_s];
                        sp_s = sp_dec_s;
                    end else begin
                        pc_s  = pc_inc_s;
                        err_s = 1'b1;
                    end
                end else if (Call) begin
                    // A full stack drops the push but the call still transfers control.
                    pc_s = target;
                    if (sp_r == SP_FULL) begin
                        err_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                        sp_s   = sp_r + SPW'(1);
                    end
                end else if (Jump) begin
                    pc_s = target;
                end else begin
                    pc_s = pc_inc_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = {D{1'b0}};
                sp_s    = SP_ZERO;
                err_s   = 1'b0;
            end
        endcase
    end

    // Sequencer state, PC, stack pointer and registered status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
            pc_r    <= {D{1'b0}};
            sp_r    <= SP_ZERO;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            sp_r    <= sp_s;
            err_r   <= err_s;
            valid_r <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Return-address storage; contents are don't-care until pushed.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            ras_r[push_idx_s] <= pc_inc_s;
        end
    end

endmodule
